// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: the ROM request/response pair, the branch redirect
// inputs and the valid/ready hand-off towards decode.
// master = the fetch unit, slave = its environment (ROM, branch unit, decode).
interface instr_fetch_unit_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, addresses the combinational ROM every
// cycle, captures {pc, word} into a DEPTH-entry FIFO and hands entries to
// decode over valid/ready. A redirect flushes the FIFO and reloads the PC.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (halt + sticky fetch_fault
// when a fetch would read past the end of the ROM).
module instr_fetch_unit #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [63:0]      pc_q,    pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_q,    rd_d;
  logic [PTR_W-1:0] wr_q,    wr_d;
  logic             fault_q, fault_d;

  logic [63:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];

  logic        pop_s;
  logic        would_push_s;
  logic        push_s;
  logic        halted_s;
  logic        nonempty_s;
  logic [63:0] target_s;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic out_of_range_s;
  logic target_ok_s;
`endif

  assign target_s   = {bus.redirect_pc[63:2], 2'b00};
  assign nonempty_s = (count_q != {CNT_W{1'b0}});
  assign halted_s   = fault_q;

  // Handshake decode and next-state computation for PC, pointers and fault.
  always_comb begin
    pop_s        = nonempty_s & bus.if_ready & ~bus.redirect_valid;
    would_push_s = ~bus.redirect_valid & ~halted_s &
                   ((count_q < CNT_W'(DEPTH)) | pop_s);
`ifdef FETCH_BOUNDS_CHECK_EN
    // 65-bit sums so a PC near 2^64 cannot wrap into the valid range.
    out_of_range_s = (({1'b0, pc_q} + 65'd3) >= 65'(MEM_SIZE));
    target_ok_s    = (({1'b0, target_s} + 65'd3) < 65'(MEM_SIZE));
    push_s         = would_push_s & ~out_of_range_s;
`else
    push_s         = would_push_s;
`endif

    pc_d    = pc_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    fault_d = fault_q;

    if (bus.redirect_valid) begin
      pc_d    = target_s;
      count_d = {CNT_W{1'b0}};
      rd_d    = {PTR_W{1'b0}};
      wr_d    = {PTR_W{1'b0}};
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_d = fault_q & ~target_ok_s;
`else
      fault_d = 1'b0;
`endif
    end else begin
      if (push_s) begin
        pc_d = pc_q + 64'd4;
        wr_d = wr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        pc_d = pc_q;
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_d = fault_q | (would_push_s & out_of_range_s);
`else
      fault_d = 1'b0;
`endif
    end
  end

  // State registers and FIFO storage; reset clears everything including data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= {CNT_W{1'b0}};
      rd_q    <= {PTR_W{1'b0}};
      wr_q    <= {PTR_W{1'b0}};
      fault_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_pc_q[i]    <= 64'h0;
        buf_instr_q[i] <= 32'h0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      if (push_s) begin
        buf_pc_q[wr_q]    <= pc_q;
        buf_instr_q[wr_q] <= bus.imem_instr;
      end
    end
  end

  // ROM address is the PC itself; head of the FIFO faces decode.
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = nonempty_s & ~bus.redirect_valid;
  assign bus.if_instr    = buf_instr_q[rd_q];
  assign bus.if_pc       = buf_pc_q[rd_q];
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned DEPTH    = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.MEM_SIZE(MEM_SIZE), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rom(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  assign bus.imem_instr = rom(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.if_ready       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 64'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.if_instr); end
    checks++; if (bus.fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.fetch_fault); end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.if_valid); end
      checks++; if (bus.if_pc !== 64'(4*k)) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.if_pc, 64'(4*k)); end
      checks++; if (bus.if_instr !== rom(64'(4*k))) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.if_instr, rom(64'(4*k))); end
      checks++; if (bus.imem_addr !== 64'(4*k+4)) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 64'(4*k+4)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.if_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.if_valid !== (c != 0)) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, bus.if_valid, (c != 0)); end
      checks++; if (bus.imem_addr !== ((c < 2) ? 64'(4*c) : 64'h8)) begin failures++; $display("FAIL bp_addr c=%0d got=%h", c, bus.imem_addr); end
      if (c != 0) begin
        checks++; if (bus.if_pc !== 64'h0) begin failures++; $display("FAIL bp_hold_pc c=%0d got=%h exp=0", c, bus.if_pc); end
      end
      tick();
    end
    // Full FIFO with ready high: one pop and one push per cycle, two ahead.
    bus.if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL full_valid k=%0d got=%b exp=1", k, bus.if_valid); end
      checks++; if (bus.if_pc !== 64'(4*k)) begin failures++; $display("FAIL full_pc k=%0d got=%h exp=%h", k, bus.if_pc, 64'(4*k)); end
      checks++; if (bus.imem_addr !== 64'(4*k+8)) begin failures++; $display("FAIL full_addr k=%0d got=%h exp=%h", k, bus.imem_addr, 64'(4*k+8)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.if_ready = 1'b0;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h43;
    bus.if_ready       = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL redir_valid0 got=%b exp=0", bus.if_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 64'h40) begin failures++; $display("FAIL redir_addr got=%h exp=40", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL redir_valid1 got=%b exp=0", bus.if_valid); end
    tick();
    checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL redir_valid2 got=%b exp=1", bus.if_valid); end
    checks++; if (bus.if_pc !== 64'h40) begin failures++; $display("FAIL redir_pc got=%h exp=40", bus.if_pc); end
    checks++; if (bus.if_instr !== rom(64'h40)) begin failures++; $display("FAIL redir_instr got=%h exp=%h", bus.if_instr, rom(64'h40)); end
    tick();
    checks++; if (bus.if_pc !== 64'h44) begin failures++; $display("FAIL redir_next got=%h exp=44", bus.if_pc); end
`ifndef FETCH_BOUNDS_CHECK_EN
    // PC wrap at the top of the 64-bit space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h", bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 64'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%h", bus.if_pc); end
`endif
  endtask

  task automatic test_reset_over_redirect();
    do_reset();
    bus.if_ready = 1'b0;
    tick();
    tick();
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    bus.if_ready       = 1'b1;
    tick();
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.if_ready       = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 64'h0) begin failures++; $display("FAIL rstrd_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rstrd_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.fetch_fault !== 1'b0) begin failures++; $display("FAIL rstrd_fault got=%b exp=0", bus.fetch_fault); end
    tick();
    checks++; if (bus.if_pc !== 64'h0) begin failures++; $display("FAIL rstrd_pc got=%h exp=0", bus.if_pc); end
  endtask

`ifdef FETCH_BOUNDS_CHECK_EN
  task automatic test_bounds();
    do_reset();
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3F8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    checks++; if (bus.if_pc !== 64'h3F8 || bus.if_valid !== 1'b1) begin failures++; $display("FAIL bnd_e0 pc=%h v=%b", bus.if_pc, bus.if_valid); end
    tick();
    checks++; if (bus.if_pc !== 64'h3FC || bus.if_valid !== 1'b1) begin failures++; $display("FAIL bnd_e1 pc=%h v=%b", bus.if_pc, bus.if_valid); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.fetch_fault !== 1'b1) begin failures++; $display("FAIL bnd_fault k=%0d got=%b exp=1", k, bus.fetch_fault); end
      checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL bnd_novalid k=%0d got=%b exp=0", k, bus.if_valid); end
      tick();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.fetch_fault !== 1'b0) begin failures++; $display("FAIL bnd_clear got=%b exp=0", bus.fetch_fault); end
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0) begin failures++; $display("FAIL bnd_restart v=%b pc=%h", bus.if_valid, bus.if_pc); end
  endtask
`endif

  task automatic test_random();
    longint unsigned q[$];
    longint unsigned mpc;
    bit              mhalt;
    bit              rv;
    bit              rdy;
    bit              pop;
    bit              wp;
    bit              exp_valid;
    longint unsigned rpc;
    int              sz;
    do_reset();
    mpc   = 64'h0;
    mhalt = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = 64'($urandom_range(0, MEM_SIZE + 24));
      bus.if_ready       = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
      exp_valid = (q.size() > 0) && !rv;
      checks++; if (bus.imem_addr !== mpc) begin failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.imem_addr, mpc); end
      checks++; if (bus.if_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.if_valid, exp_valid); end
      checks++; if (bus.fetch_fault !== mhalt) begin failures++; $display("FAIL rnd_fault n=%0d got=%b exp=%b", n, bus.fetch_fault, mhalt); end
      if (exp_valid) begin
        checks++; if (bus.if_pc !== q[0] || bus.if_instr !== rom(q[0])) begin failures++; $display("FAIL rnd_head n=%0d pc=%h instr=%h exp_pc=%h", n, bus.if_pc, bus.if_instr, q[0]); end
      end
      // Reference model update for this clock edge.
      if (rv) begin
        q.delete();
        mpc = rpc & ~64'h3;
`ifdef FETCH_BOUNDS_CHECK_EN
        if (mhalt && (mpc + 3 < MEM_SIZE)) mhalt = 1'b0;
`endif
      end else begin
        sz  = q.size();
        pop = exp_valid && rdy;
        if (pop) void'(q.pop_front());
        wp = !mhalt && ((sz < DEPTH) || pop);
        if (wp) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (mpc + 3 >= MEM_SIZE) begin
            mhalt = 1'b1;
          end else begin
            q.push_back(mpc);
            mpc = mpc + 4;
          end
`else
          q.push_back(mpc);
          mpc = mpc + 4;
`endif
        end
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.if_ready       = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_reset_over_redirect();
`ifdef FETCH_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
